// File: rtl/pong_graphics.sv
// Pong pixel generator. It sits behind the VGA timing stage and holds the game
// state: a wall, a button-driven paddle, a ball and a BCD hit counter. The game
// objects move once per frame, on a tick raised at the start of vertical
// blanking, so the visible picture never tears. Colour is registered once to
// stay aligned with the registered sync outputs of the timing stage.
module pong_graphics #(
    parameter int PAD_H       = 72,
    parameter int PAD_V       = 4,
    parameter int BALL_SZ     = 8,
    parameter int BALL_V      = 2,
    parameter int MISS_FRAMES = 60
) (
    input  logic       clk25M,
    input  logic       reset,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    input  logic       vga_on,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [7:0] rgb,
    output logic [7:0] score,
    output logic [1:0] game_state
);
    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_PLAY = 2'd1,
        ST_MISS = 2'd2
    } state_t;

    localparam int MISS_W = $clog2(MISS_FRAMES);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_FRAMES - 1);

    // Start positions: paddle and ball centred vertically, ball centred on screen.
    localparam logic [9:0]  PAD_Y0      = 10'((480 - PAD_H) / 2);
    localparam logic [9:0]  BALL_X0     = 10'(320 - BALL_SZ / 2);
    localparam logic [9:0]  BALL_Y0     = 10'(240 - BALL_SZ / 2);
    localparam logic [9:0]  PAD_V10     = 10'(PAD_V);
    localparam logic [9:0]  BALL_V10    = 10'(BALL_V);
    localparam logic [10:0] PAD_V11     = 11'(PAD_V);
    localparam logic [10:0] PAD_H11     = 11'(PAD_H);
    localparam logic [10:0] PAD_MAX     = 11'(480 - PAD_H);
    localparam logic [10:0] BALL_SZ11   = 11'(BALL_SZ);
    localparam logic [10:0] BALL_V11    = 11'(BALL_V);
    localparam logic [10:0] BOTTOM_LIM  = 11'(480 - BALL_SZ - BALL_V);
    localparam logic [10:0] WALL_LIM    = 11'(40 + BALL_V);
    localparam logic [10:0] RIGHT_LIM   = 11'(640 - BALL_SZ);
    localparam logic [10:0] PAD_X0      = 11'd600;
    localparam logic [10:0] PAD_X1      = 11'd603;
    localparam logic [10:0] WALL_X0     = 11'd32;
    localparam logic [10:0] WALL_X1     = 11'd39;

    state_t              state_reg, state_next;
    logic                tick_reg;
    logic [9:0]          pad_y_reg, pad_y_next;
    logic [9:0]          bx_reg, bx_next;
    logic [9:0]          by_reg, by_next;
    logic                dx_reg, dx_next;     // 1 = moving right
    logic                dy_reg, dy_next;     // 1 = moving down
    logic [MISS_W-1:0]   miss_reg, miss_next;
    logic [7:0]          score_reg, score_next;
    logic [7:0]          rgb_reg, rgb_next;
    logic                ball_hit_pad, ball_missed;

    // Zero-extended copies so every coordinate sum is formed without wrapping.
    logic [10:0] pad_ext, bx_ext, by_ext, h_ext, v_ext;
    assign pad_ext = {1'b0, pad_y_reg};
    assign bx_ext  = {1'b0, bx_reg};
    assign by_ext  = {1'b0, by_reg};
    assign h_ext   = {1'b0, hcount};
    assign v_ext   = {1'b0, vcount};

    function automatic logic [7:0] bcd_inc(input logic [7:0] s);
        logic [3:0] lo;
        logic [3:0] hi;
        lo = s[3:0];
        hi = s[7:4];
        if (lo == 4'd9) begin
            lo = 4'd0;
            hi = (hi == 4'd9) ? 4'd0 : hi + 4'd1;
        end else begin
            lo = lo + 4'd1;
        end
        return {hi, lo};
    endfunction

    // Paddle moves on every tick regardless of game state; opposing buttons cancel.
    always_comb begin
        pad_y_next = pad_y_reg;
        if (tick_reg) begin
            if (btn_up && !btn_down) begin
                pad_y_next = (pad_ext >= PAD_V11) ? pad_y_reg - PAD_V10 : 10'd0;
            end else if (btn_down && !btn_up) begin
                pad_y_next = (pad_ext + PAD_V11 <= PAD_MAX) ? pad_y_reg + PAD_V10 : PAD_MAX[9:0];
            end
        end
    end

    // Game FSM: serve, ball bounce/hit/miss resolution, miss hold-off.
    // The hit test uses the paddle position from before this tick's paddle move.
    always_comb begin
        state_next   = state_reg;
        bx_next      = bx_reg;
        by_next      = by_reg;
        dx_next      = dx_reg;
        dy_next      = dy_reg;
        miss_next    = miss_reg;
        score_next   = score_reg;
        ball_hit_pad = 1'b0;
        ball_missed  = 1'b0;
        if (tick_reg) begin
            case (state_reg)
                ST_WAIT: begin
                    if (btn_up || btn_down) begin
                        state_next = ST_PLAY;
                        dx_next    = 1'b1;
                        dy_next    = 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (!dy_reg && by_ext <= BALL_V11) begin
                        dy_next = 1'b1;
                    end else if (dy_reg && by_ext >= BOTTOM_LIM) begin
                        dy_next = 1'b0;
                    end
                    if (!dx_reg && bx_ext <= WALL_LIM) begin
                        dx_next = 1'b1;
                    end
                    ball_hit_pad = dx_next
                                && (bx_ext + BALL_SZ11 >= PAD_X0) && (bx_ext <= PAD_X1)
                                && (by_ext + BALL_SZ11 > pad_ext) && (by_ext < pad_ext + PAD_H11);
                    ball_missed  = !ball_hit_pad && (bx_ext >= RIGHT_LIM);
                    if (ball_hit_pad) begin
                        dx_next    = 1'b0;
                        score_next = bcd_inc(score_reg);
                    end
                    if (ball_missed) begin
                        state_next = ST_MISS;
                        miss_next  = '0;
                    end else begin
                        bx_next = dx_next ? bx_reg + BALL_V10 : bx_reg - BALL_V10;
                        by_next = dy_next ? by_reg + BALL_V10 : by_reg - BALL_V10;
                    end
                end
                ST_MISS: begin
                    if (miss_reg == MISS_LAST) begin
                        state_next = ST_WAIT;
                        miss_next  = '0;
                        score_next = 8'h00;
                        bx_next    = BALL_X0;
                        by_next    = BALL_Y0;
                    end else begin
                        miss_next = miss_reg + MISS_W'(1);
                    end
                end
                default: state_next = ST_WAIT;
            endcase
        end
    end

    // Pixel colour for the raster position currently presented, by object priority.
    always_comb begin
        rgb_next = 8'h00;
        if (vga_on) begin
            if (state_reg != ST_MISS
                && h_ext >= bx_ext && h_ext < bx_ext + BALL_SZ11
                && v_ext >= by_ext && v_ext < by_ext + BALL_SZ11) begin
                rgb_next = 8'hE0;
            end else if (h_ext >= PAD_X0 && h_ext <= PAD_X1
                         && v_ext >= pad_ext && v_ext < pad_ext + PAD_H11) begin
                rgb_next = 8'h1C;
            end else if (h_ext >= WALL_X0 && h_ext <= WALL_X1) begin
                rgb_next = 8'h03;
            end
        end
    end

    // State registers; frame tick is raised the cycle after (0,480) is sampled.
    always_ff @(posedge clk25M or posedge reset) begin
        if (reset) begin
            tick_reg  <= 1'b0;
            state_reg <= ST_WAIT;
            pad_y_reg <= PAD_Y0;
            bx_reg    <= BALL_X0;
            by_reg    <= BALL_Y0;
            dx_reg    <= 1'b1;
            dy_reg    <= 1'b1;
            miss_reg  <= '0;
            score_reg <= 8'h00;
            rgb_reg   <= 8'h00;
        end else begin
            tick_reg  <= (hcount == 10'd0) && (vcount == 10'd480);
            state_reg <= state_next;
            pad_y_reg <= pad_y_next;
            bx_reg    <= bx_next;
            by_reg    <= by_next;
            dx_reg    <= dx_next;
            dy_reg    <= dy_next;
            miss_reg  <= miss_next;
            score_reg <= score_next;
            rgb_reg   <= rgb_next;
        end
    end

    assign rgb        = rgb_reg;
    assign score      = score_reg;
    assign game_state = state_reg;

endmodule

// File: tb/tb_pong_graphics.sv
// Bench for pong_graphics: a behavioural game model predicts every pixel,
// score and state; expected pixels are queued as stimulus is driven and
// compared one cycle later when the registered colour appears.
module tb_pong_graphics;
    logic       clk25M = 1'b0;
    logic       reset = 1'b0;
    logic [9:0] hcount = '0;
    logic [9:0] vcount = '0;
    logic       vga_on = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic [7:0] rgb;
    logic [7:0] score;
    logic [1:0] game_state;

    int n_checks = 0;
    int n_pass = 0;
    logic [7:0] exp_q[$];

    // Reference game model
    int m_pad, m_bx, m_by, m_state, m_miss, m_score, m_hits;
    bit m_dx, m_dy, m_tick;

    pong_graphics dut (
        .clk25M(clk25M), .reset(reset), .hcount(hcount), .vcount(vcount),
        .vga_on(vga_on), .btn_up(btn_up), .btn_down(btn_down),
        .rgb(rgb), .score(score), .game_state(game_state)
    );

    always #20 clk25M = ~clk25M;

    initial begin
        #10ms;
        $display("FAIL watchdog: got no finish, expected finish before 10ms");
        $fatal(1, "watchdog");
    end

    task automatic finish_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    endtask

    task automatic model_reset();
        m_pad = 204; m_bx = 316; m_by = 236; m_dx = 1; m_dy = 1;
        m_state = 0; m_miss = 0; m_score = 0; m_hits = 0; m_tick = 0;
        exp_q.delete();
    endtask

    function automatic logic [7:0] to_bcd(input int s);
        return {4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [7:0] model_rgb(input int h, input int v, input bit on);
        if (!on) return 8'h00;
        if (m_state != 2 && h >= m_bx && h < m_bx + 8 && v >= m_by && v < m_by + 8) return 8'hE0;
        if (h >= 600 && h <= 603 && v >= m_pad && v < m_pad + 72) return 8'h1C;
        if (h >= 32 && h <= 39) return 8'h03;
        return 8'h00;
    endfunction

    // One frame update of the model; the hit test sees the pre-tick paddle.
    task automatic model_tick(input bit up, input bit down);
        int  old_pad;
        bit  skip_move;
        old_pad = m_pad;
        skip_move = 0;
        case (m_state)
            0: if (up || down) begin m_state = 1; m_dx = 1; m_dy = 1; end
            1: begin
                if (m_dy == 0 && m_by <= 2) m_dy = 1;
                else if (m_dy == 1 && m_by >= 470) m_dy = 0;
                if (m_dx == 0 && m_bx <= 42) m_dx = 1;
                if (m_dx == 1 && m_bx + 8 >= 600 && m_bx <= 603
                    && m_by + 8 > old_pad && m_by < old_pad + 72) begin
                    m_dx = 0;
                    m_score = (m_score + 1) % 100;
                    m_hits++;
                end else if (m_bx >= 632) begin
                    m_state = 2; m_miss = 0; skip_move = 1;
                end
                if (!skip_move) begin
                    m_bx = m_dx ? m_bx + 2 : m_bx - 2;
                    m_by = m_dy ? m_by + 2 : m_by - 2;
                end
            end
            default: begin
                if (m_miss == 59) begin
                    m_state = 0; m_miss = 0; m_score = 0; m_bx = 316; m_by = 236;
                end else begin
                    m_miss++;
                end
            end
        endcase
        if (up && !down) m_pad = (m_pad >= 4) ? m_pad - 4 : 0;
        else if (down && !up) m_pad = (m_pad + 4 <= 408) ? m_pad + 4 : 408;
    endtask

    // Drive one cycle; queue the expected pixel, pop and compare after the edge.
    task automatic step(input int h, input int v, input bit on, input bit up, input bit down,
                        input int exp_over);
        logic [7:0] e;
        logic [7:0] want;
        hcount = 10'(h); vcount = 10'(v); vga_on = on; btn_up = up; btn_down = down;
        if (exp_over >= 0) e = 8'(exp_over);
        else if (reset) e = 8'h00;
        else e = model_rgb(h, v, on);
        exp_q.push_back(e);
        if (!reset) begin
            if (m_tick) model_tick(up, down);
            m_tick = (h == 0 && v == 480);
        end
        @(posedge clk25M);
        #1;
        want = exp_q.pop_front();
        n_checks++;
        if (rgb !== want) $display("FAIL rgb_pixel (%0d,%0d): got %h expected %h", h, v, rgb, want);
        else n_pass++;
        n_checks++;
        if (score !== to_bcd(m_score)) $display("FAIL score: got %h expected %h", score, to_bcd(m_score));
        else n_pass++;
        n_checks++;
        if (game_state !== 2'(m_state)) $display("FAIL game_state: got %0d expected %0d", game_state, m_state);
        else n_pass++;
        if (v < 480)
            $display("txn pixel (%0d,%0d) on=%0b rgb=%h score=%h state=%0d", h, v, on, rgb, score, game_state);
        if (n_checks - n_pass > 40) begin
            $display("FAIL error_limit: got %0d failures, expected 0", n_checks - n_pass);
            finish_run();
        end
    endtask

    task automatic frames(input int n, input bit up, input bit down);
        for (int i = 0; i < n; i++) begin
            step(0, 480, 1'b0, up, down, -1);
            step(0, 481, 1'b0, up, down, -1);
        end
    endtask

    task automatic probe(input int h, input int v, input int exp_over);
        step(h, v, (h < 640 && v < 480), 1'b0, 1'b0, exp_over);
    endtask

    // Frame tick every cycle, paddle steered to track the ball, until a hit count.
    task automatic steer_until(input int hits_target, input int budget, output bit ok);
        bit up, down;
        int target;
        ok = 0;
        for (int i = 0; i < budget && m_hits < hits_target; i++) begin
            target = m_by - 32;
            if (target < 0) target = 0;
            if (target > 408) target = 408;
            up = (m_pad > target + 3);
            down = (m_pad < target - 3);
            step(0, 480, 1'b0, up, down, -1);
        end
        ok = (m_hits >= hits_target);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        n_checks++; if (rgb !== 8'h00) $display("FAIL reset_rgb: got %h expected 00", rgb); else n_pass++;
        n_checks++; if (score !== 8'h00) $display("FAIL reset_score: got %h expected 00", score); else n_pass++;
        n_checks++; if (game_state !== 2'd0) $display("FAIL reset_state: got %0d expected 0", game_state); else n_pass++;
        step(100, 100, 1'b1, 1'b0, 1'b0, -1);
        step(100, 100, 1'b1, 1'b0, 1'b0, -1);
        reset = 1'b0;
        step(100, 100, 1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_reset();
        do_reset();
        probe(320, 240, 8'hE0);
        probe(34, 10, 8'h03);
        probe(601, 204, 8'h1C);
        probe(700, 10, 8'h00);
        probe(315, 236, 8'h00);
        probe(601, 276, 8'h00);
    endtask

    task automatic test_paddle();
        do_reset();
        frames(50, 1'b0, 1'b1);
        probe(601, 404, 8'h1C);
        probe(601, 403, 8'h00);
        frames(10, 1'b0, 1'b1);
        probe(601, 407, 8'h00);
        probe(601, 408, 8'h1C);
        probe(603, 479, 8'h1C);
        frames(110, 1'b1, 1'b0);
        probe(601, 0, 8'h1C);
        probe(601, 71, 8'h1C);
        probe(601, 72, 8'h00);
        probe(604, 10, 8'h00);
        frames(20, 1'b1, 1'b1);
        probe(600, 0, 8'h1C);
        probe(601, 72, 8'h00);
    endtask

    task automatic test_serve();
        do_reset();
        frames(1, 1'b1, 1'b0);
        n_checks++; if (game_state !== 2'd1) $display("FAIL serve_state: got %0d expected 1", game_state); else n_pass++;
        probe(316, 236, 8'hE0);
        frames(1, 1'b0, 1'b0);
        probe(318, 238, 8'hE0);
        probe(317, 238, 8'h00);
        probe(325, 245, 8'hE0);
        probe(326, 238, 8'h00);
        frames(116, 1'b0, 1'b0);
        probe(550, 470, 8'hE0);
        probe(550, 469, 8'h00);
        probe(557, 477, 8'hE0);
        frames(1, 1'b0, 1'b0);
        probe(552, 468, 8'hE0);
        probe(552, 476, 8'h00);
        probe(552, 467, 8'h00);
    endtask

    task automatic test_hit();
        bit ok;
        int px, py;
        do_reset();
        frames(1, 1'b0, 1'b1);
        steer_until(1, 1000, ok);
        n_checks++; if (!ok) $display("FAIL hit_timeout: got %0d hits, expected 1", m_hits); else n_pass++;
        n_checks++; if (score !== 8'h01) $display("FAIL hit_score: got %h expected 01", score); else n_pass++;
        n_checks++; if (game_state !== 2'd1) $display("FAIL hit_state: got %0d expected 1", game_state); else n_pass++;
        step(0, 0, 1'b0, 1'b0, 1'b0, -1);
        px = m_bx; py = m_by;
        probe(px, py, -1);
        probe(px + 7, py + 7, -1);
        probe(px - 1, py, -1);
        probe(px + 8, py, -1);
    endtask

    task automatic test_score_wrap();
        bit ok;
        steer_until(99, 56000, ok);
        n_checks++; if (!ok) $display("FAIL wrap_99_timeout: got %0d hits, expected 99", m_hits); else n_pass++;
        n_checks++; if (score !== 8'h99) $display("FAIL score_99: got %h expected 99", score); else n_pass++;
        steer_until(100, 700, ok);
        n_checks++; if (!ok) $display("FAIL wrap_timeout: got %0d hits, expected 100", m_hits); else n_pass++;
        n_checks++; if (score !== 8'h00) $display("FAIL score_wrap: got %h expected 00", score); else n_pass++;
        n_checks++; if (game_state !== 2'd1) $display("FAIL wrap_state: got %0d expected 1", game_state); else n_pass++;
    endtask

    task automatic test_miss();
        do_reset();
        frames(1, 1'b1, 1'b0);
        frames(157, 1'b1, 1'b0);
        probe(630, 390, 8'hE0);
        probe(637, 397, 8'hE0);
        probe(629, 390, 8'h00);
        frames(1, 1'b1, 1'b0);
        probe(632, 388, 8'hE0);
        frames(1, 1'b0, 1'b0);
        n_checks++; if (game_state !== 2'd2) $display("FAIL miss_enter: got %0d expected 2", game_state); else n_pass++;
        probe(632, 388, 8'h00);
        probe(601, 0, 8'h1C);
        frames(59, 1'b0, 1'b0);
        n_checks++; if (game_state !== 2'd2) $display("FAIL miss_hold: got %0d expected 2", game_state); else n_pass++;
        frames(1, 1'b0, 1'b0);
        n_checks++; if (game_state !== 2'd0) $display("FAIL miss_exit: got %0d expected 0", game_state); else n_pass++;
        n_checks++; if (score !== 8'h00) $display("FAIL miss_score: got %h expected 00", score); else n_pass++;
        probe(316, 236, 8'hE0);
        probe(323, 243, 8'hE0);
        probe(632, 388, 8'h00);
    endtask

    task automatic test_reset_mid_miss();
        do_reset();
        frames(1, 1'b1, 1'b0);
        frames(158, 1'b1, 1'b0);
        frames(1, 1'b0, 1'b0);
        frames(30, 1'b0, 1'b0);
        n_checks++; if (game_state !== 2'd2) $display("FAIL mid_miss_state: got %0d expected 2", game_state); else n_pass++;
        probe(34, 10, 8'h03);
        do_reset();
        probe(320, 240, 8'hE0);
        probe(601, 204, 8'h1C);
        frames(1, 1'b0, 1'b1);
        n_checks++; if (game_state !== 2'd1) $display("FAIL after_reset_serve: got %0d expected 1", game_state); else n_pass++;
        probe(601, 208, 8'h1C);
        probe(601, 207, 8'h00);
    endtask

    initial begin
        model_reset();
        #5;
        test_reset();
        test_paddle();
        test_serve();
        test_miss();
        test_reset_mid_miss();
        test_hit();
        test_score_wrap();
        finish_run();
    end

endmodule
